// File: rtl/adn_seq_display.sv
// ---------------------------------------------------------------------------
// adn_seq_display
//   Scrolling nucleotide display driver for a bank of 7-segment digits.
//   Nucleotide codes arrive over a valid/ready handshake, wait in a small
//   FIFO, and are shifted one per scroll step into an N-digit window.
//   Each window digit is decoded to an active-low segment pattern.
//
//   Handshake: a code is transferred on a rising clk edge where
//   in_valid && in_ready (and clear is low); in_data is ignored otherwise.
//   in_ready is high whenever the FIFO is not full and does not depend on
//   in_valid.
//
//   Optional feature macro: ADN_SEQ_BLINK_N_EN
//     When defined, a blink phase toggles on every scroll tick and valid
//     digits holding N (3'b111) are blanked while the phase is 1.
//
// Parameters
//   NUM_DIGITS  digits in the display window (1..16)
//   FIFO_DEPTH  input buffer entries (power of two, >= 2)
//   SCROLL_DIV  clock cycles per scroll step (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   clear       synchronous flush of FIFO, window, scroll counter, shown_cnt
//   freeze      holds scroll counter and window; FIFO still accepts input
//   in_valid    in_data is valid
//   in_data     nucleotide code: A=001 G=010 T=011 C=100 N=111
//   in_ready    FIFO not full
//   hex         active-low segments, hex[6:0] is digit 0 (newest)
//   fifo_count  entries currently buffered
//   shown_cnt   codes shifted into the window (wraps)
// ---------------------------------------------------------------------------
module adn_seq_display #(
  parameter int NUM_DIGITS = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          freeze,
  input  logic                          in_valid,
  input  logic [2:0]                    in_data,
  output logic                          in_ready,
  output logic [7*NUM_DIGITS-1:0]       hex,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   shown_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SCROLL_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCROLL_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // ---------------- scroll counter ----------------
  logic [CW-1:0] scroll_cnt;
  logic          tick;

  assign tick = !freeze && (scroll_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_cnt <= '0;
    end else if (clear) begin
      scroll_cnt <= '0;
    end else if (!freeze) begin
      scroll_cnt <= tick ? '0 : scroll_cnt + 1'b1;
    end
  end

  // ---------------- input FIFO ----------------
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready = (fifo_count != FULL_CNT);
  // clear wins over everything; pop decision uses the pre-edge count, so a
  // code pushed in the tick cycle cannot be popped by that same tick.
  assign push = in_valid && in_ready && !clear;
  assign pop  = tick && (fifo_count != '0) && !clear;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- display window ----------------
  logic [NUM_DIGITS-1:0][2:0] dig_code;
  logic [NUM_DIGITS-1:0]      dig_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_code  <= '0;
      dig_valid <= '0;
      shown_cnt <= '0;
    end else if (clear) begin
      dig_code  <= '0;
      dig_valid <= '0;
      shown_cnt <= '0;
    end else if (pop) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        dig_code[k]  <= dig_code[k-1];
        dig_valid[k] <= dig_valid[k-1];
      end
      dig_code[0]  <= mem[rd_ptr];
      dig_valid[0] <= 1'b1;
      shown_cnt    <= shown_cnt + 16'd1;
    end
  end

`ifdef ADN_SEQ_BLINK_N_EN
  // Blink phase advances on every tick, even when nothing is popped.
  logic blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_phase <= 1'b0;
    end else if (clear) begin
      blink_phase <= 1'b0;
    end else if (tick) begin
      blink_phase <= !blink_phase;
    end
  end
`endif

  // ---------------- segment decode ----------------
  function automatic logic [6:0] seg_of(input logic [2:0] c);
    case (c)
      3'b001:  seg_of = 7'b0001000;  // A
      3'b010:  seg_of = 7'b1000010;  // G
      3'b011:  seg_of = 7'b1001110;  // T
      3'b100:  seg_of = 7'b1000110;  // C
      3'b111:  seg_of = 7'b1001000;  // N
      // Undefined codes expose their raw bits on three segments.
      default: seg_of = {c[2], 1'b1, 1'b1, c[1], 1'b1, 1'b1, c[0]};
    endcase
  endfunction

  always_comb begin
    hex = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_valid[k]) begin
`ifdef ADN_SEQ_BLINK_N_EN
        if (!(blink_phase && dig_code[k] == 3'b111)) begin
          hex[7*k +: 7] = seg_of(dig_code[k]);
        end
`else
        hex[7*k +: 7] = seg_of(dig_code[k]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_adn_seq_display.sv
// ---------------------------------------------------------------------------
// tb_adn_seq_display
//   Self-checking bench for adn_seq_display (NUM_DIGITS=4, FIFO_DEPTH=4,
//   SCROLL_DIV=4). A queue-based reference model tracks the FIFO, the
//   window and the scroll phase; every cycle's outputs are compared to it.
//   A decode table and hand-written sequences cover the corner cases.
//   Honours ADN_SEQ_BLINK_N_EN if defined.
// ---------------------------------------------------------------------------
module tb_adn_seq_display;

  localparam int ND = 4;
  localparam int FD = 4;
  localparam int SD = 4;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          freeze;
  logic          in_valid;
  logic [2:0]    in_data;
  logic          in_ready;
  logic [7*ND-1:0] hex;
  logic [2:0]    fifo_count;
  logic [15:0]   shown_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adn_seq_display #(
    .NUM_DIGITS(ND),
    .FIFO_DEPTH(FD),
    .SCROLL_DIV(SD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .freeze     (freeze),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .hex        (hex),
    .fifo_count (fifo_count),
    .shown_cnt  (shown_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_fifo[$];     // buffered codes, oldest first
  int m_win[$];      // window, index 0 = newest; -1 = blank digit
  int m_active;      // unfrozen cycles since reset/clear
  int m_shown;
  bit m_phase;

  function automatic void model_reset();
    m_fifo.delete();
    m_win.delete();
    for (int k = 0; k < ND; k++) m_win.push_back(-1);
    m_active = 0;
    m_shown  = 0;
    m_phase  = 1'b0;
  endfunction

  // A scroll step happens on every SD-th unfrozen cycle.
  function automatic bit model_tick_next(input bit frz);
    return !frz && ((m_active % SD) == SD - 1);
  endfunction

  function automatic void model_step(input bit v, input int d, input bit clr, input bit frz);
    bit tk;
    bit rdy;
    if (clr) begin
      model_reset();
      return;
    end
    tk  = model_tick_next(frz);
    rdy = (m_fifo.size() != FD);
    if (!frz) m_active++;
    if (tk) begin
`ifdef ADN_SEQ_BLINK_N_EN
      m_phase = !m_phase;
`endif
      if (m_fifo.size() > 0) begin
        m_win.push_front(m_fifo.pop_front());
        void'(m_win.pop_back());
        m_shown = (m_shown + 1) % 65536;
      end
    end
    if (v && rdy) m_fifo.push_back(d);
  endfunction

  function automatic logic [6:0] model_seg(input int c, input bit ph);
    logic [2:0] b;
    if (c < 0) return 7'b1111111;
    b = c[2:0];
    case (c)
      1: return 7'b0001000;
      2: return 7'b1000010;
      3: return 7'b1001110;
      4: return 7'b1000110;
      7: return ph ? 7'b1111111 : 7'b1001000;
      default: return {b[2], 1'b1, 1'b1, b[1], 1'b1, 1'b1, b[0]};
    endcase
  endfunction

  function automatic logic [7*ND-1:0] model_hex();
    logic [7*ND-1:0] e;
    for (int k = 0; k < ND; k++) e[7*k +: 7] = model_seg(m_win[k], m_phase);
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, " hex"},        32'(hex),        32'(model_hex()));
    chk({tag, " in_ready"},   32'(in_ready),   32'(m_fifo.size() != FD));
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'(m_fifo.size()));
    chk({tag, " shown_cnt"},  32'(shown_cnt),  32'(m_shown));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, clock, advance model, then check.
  task automatic drive_cycle(input bit v, input int d, input bit clr, input bit frz, input string tag);
    in_valid = v;
    in_data  = 3'(d);
    clear    = clr;
    freeze   = frz;
    @(posedge clk);
    model_step(v, d, clr, frz);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [2:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t tbl[8];

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    bit frz_r;

    tbl[0] = '{3'b001, 7'b0001000};
    tbl[1] = '{3'b010, 7'b1000010};
    tbl[2] = '{3'b011, 7'b1001110};
    tbl[3] = '{3'b100, 7'b1000110};
`ifdef ADN_SEQ_BLINK_N_EN
    tbl[4] = '{3'b111, 7'b1111111};  // first tick turns the blink phase on
`else
    tbl[4] = '{3'b111, 7'b1001000};
`endif
    tbl[5] = '{3'b000, 7'b0110110};
    tbl[6] = '{3'b101, 7'b1110111};
    tbl[7] = '{3'b110, 7'b1111110};

    rst_n = 1'b0; clear = 1'b0; freeze = 1'b0; in_valid = 1'b0; in_data = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Idle after reset
    repeat (100) drive_cycle(0, 0, 0, 0, "idle");
    chk("idle_hex_blank", 32'(hex), 32'(28'hFFFFFFF));
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_count", 32'(fifo_count), 32'd0);
    chk("idle_shown", 32'(shown_cnt), 32'd0);

    // Decode table: one code per pass, shown in digit 0 after the first tick
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 0, 1, 0, "tbl_clr");
      drive_cycle(1, int'(tbl[i].code), 0, 0, "tbl_push");
      repeat (4) drive_cycle(0, 0, 0, 0, "tbl_idle");
      chk("dec_seg", 32'(hex[6:0]), 32'(tbl[i].seg));
      chk("dec_upper_blank", 32'(hex[7*ND-1:7]), 32'(21'h1FFFFF));
      chk("dec_shown", 32'(shown_cnt), 32'd1);
    end

    // A,G,T,C back-to-back
    drive_cycle(0, 0, 1, 0, "agtc_clr");
    drive_cycle(1, 1, 0, 0, "agtc_push");
    drive_cycle(1, 2, 0, 0, "agtc_push");
    drive_cycle(1, 3, 0, 0, "agtc_push");
    drive_cycle(1, 4, 0, 0, "agtc_push");
    repeat (16) drive_cycle(0, 0, 0, 0, "agtc_idle");
    chk("agtc_hex", 32'(hex), 32'(28'b0001000_1000010_1001110_1000110));
    chk("agtc_shown", 32'(shown_cnt), 32'd4);
    chk("agtc_count", 32'(fifo_count), 32'd0);

    // Fill under freeze, then release
    drive_cycle(0, 0, 1, 0, "full_clr");
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, int'($urandom_range(0, 7)), 0, 1, "full_push");
      if (i == 3) chk("full_ready_after_4th", 32'(in_ready), 32'd0);
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_frozen_shown", 32'(shown_cnt), 32'd0);
    repeat (3) drive_cycle(0, 0, 0, 0, "release");
    chk("release_no_pop_yet", 32'(fifo_count), 32'd4);
    drive_cycle(0, 0, 0, 0, "release");
    chk("release_first_pop", 32'(fifo_count), 32'd3);
    chk("release_ready", 32'(in_ready), 32'd1);

    // Push in the exact tick cycle with one entry buffered
    drive_cycle(0, 0, 1, 0, "tkp_clr");
    drive_cycle(1, 2, 0, 0, "tkp_push");
    n = 0;
    while (!model_tick_next(0) && n < 20) begin
      drive_cycle(0, 0, 0, 0, "tkp_wait");
      n++;
    end
    chk("tkp_wait_bound", 32'(n < 20), 32'd1);
    drive_cycle(1, 3, 0, 0, "tkp_tick");
    chk("tkp_count", 32'(fifo_count), 32'd1);
    chk("tkp_digit0_older", 32'(hex[6:0]), 32'(7'b1000010));

    // clear together with a handshake and a tick
    drive_cycle(0, 0, 1, 0, "cwt_clr");
    drive_cycle(1, 1, 0, 0, "cwt_push");
    drive_cycle(1, 4, 0, 0, "cwt_push");
    n = 0;
    while (!model_tick_next(0) && n < 20) begin
      drive_cycle(0, 0, 0, 0, "cwt_wait");
      n++;
    end
    chk("cwt_wait_bound", 32'(n < 20), 32'd1);
    drive_cycle(1, 5, 1, 0, "cwt_clear");
    chk("cwt_count", 32'(fifo_count), 32'd0);
    chk("cwt_hex", 32'(hex), 32'(28'hFFFFFFF));
    chk("cwt_shown", 32'(shown_cnt), 32'd0);
    repeat (8) drive_cycle(0, 0, 0, 0, "cwt_idle");
    chk("cwt_discarded_hex", 32'(hex), 32'(28'hFFFFFFF));
    chk("cwt_discarded_shown", 32'(shown_cnt), 32'd0);

    // N blink behaviour
    drive_cycle(0, 0, 1, 0, "blk_clr");
    drive_cycle(1, 7, 0, 0, "blk_push");
    repeat (3) drive_cycle(0, 0, 0, 0, "blk_idle");
`ifdef ADN_SEQ_BLINK_N_EN
    chk("blink_tick1", 32'(hex[6:0]), 32'(7'b1111111));
`else
    chk("blink_tick1", 32'(hex[6:0]), 32'(7'b1001000));
`endif
    repeat (4) drive_cycle(0, 0, 0, 0, "blk_idle");
    chk("blink_tick2", 32'(hex[6:0]), 32'(7'b1001000));

    // Randomized traffic against the model
    frz_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) frz_r = !frz_r;
      drive_cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 199) == 0), frz_r, "rand");
    end

    // Asynchronous reset mid-stream
    drive_cycle(1, 3, 0, 0, "arst_push");
    drive_cycle(1, 4, 0, 0, "arst_push");
    repeat (10) drive_cycle(1, 1, 0, 0, "arst_fill");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("arst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) drive_cycle(0, 0, 0, 0, "arst_after");
    chk("arst_after_hex", 32'(hex), 32'(28'hFFFFFFF));
    drive_cycle(1, 2, 0, 0, "arst_push2");
    repeat (8) drive_cycle(0, 0, 0, 0, "arst_idle2");
    chk("arst_restart_shown", 32'(shown_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adn_seq_display.md
# adn_seq_display

Multi-digit scrolling nucleotide display driver for the board's 7-segment bank. Accepts a stream of 3-bit nucleotide codes over a valid/ready handshake and buffers them in an internal FIFO. At a programmable scroll rate it shifts one code per step into an N-digit window. It drives all digits with active-low segment patterns, and is the next generation of the single-digit nucleotide-to-segment decoder, sitting between the sequence source and the board HEX pins.

## Interface
- NUM_DIGITS, 8, digits in the display window (1..16)
- FIFO_DEPTH, 16, input buffer entries (power of two, ≥2)
- SCROLL_DIV, 25000000, clock cycles per scroll step (≥2)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush: empties FIFO, blanks window, zeroes scroll counter and shown_cnt
- freeze  input  1  holds scroll counter and window; FIFO still accepts input
- in_valid  input  1  in_data is valid
- in_data  input  3  nucleotide code: A=001, G=010, T=011, C=100, N=111
- in_ready  output  1  FIFO can accept a code (not full)
- hex  output  7*NUM_DIGITS  segments, active-low; hex[6:0] is digit 0 (newest, rightmost)
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries in FIFO
- shown_cnt  output  16  codes shifted into the window, wraps 0xFFFF→0

## Operation
- Per-digit state: 3-bit code plus valid flag. Invalid digit shows 7'b1111111 (all off).
- Decode for valid digit: A→0001000, G→1000010, T→1001110, C→1000110, N→1001000, any other code d→{d[2],1,1,d[1],1,1,d[0]}.
- Handshake: push when in_valid && in_ready. in_ready = (fifo_count != FIFO_DEPTH). in_data ignored when in_valid=0.
- Scroll counter counts 0..SCROLL_DIV-1 while freeze=0. Tick is asserted in the cycle the counter equals SCROLL_DIV-1, and the counter wraps to 0.
- On tick with FIFO non-empty: digit k ← digit k-1 for k≥1; digit 0 ← popped code, valid=1; shown_cnt += 1.
- On tick with FIFO empty: window unchanged, shown_cnt unchanged.
- Simultaneous push and pop: both take effect, fifo_count unchanged. When FIFO is full no push occurs, so pop only.
- clear has priority over push, pop and tick in the same cycle. A handshake in that cycle is discarded.
- freeze=1: counter holds its value, no tick. Resumes from the held value when freeze falls.

## Timing
- Reset (rst_n=0, asynchronous): FIFO empty, fifo_count=0, in_ready=1, all digits invalid (hex all 1s), scroll counter=0, shown_cnt=0, blink phase=0.
- rst_n deassertion mid-stream discards all buffered and displayed codes.
- Window and counters are registered. hex is combinational decode of registered digit state and changes the cycle after the tick.
- fifo_count and in_ready update the cycle after a push or pop.
- Minimum latency from push into empty FIFO to display: next tick at least 1 cycle after the push. A push in the tick cycle itself is not popped by that tick.
- Throughput: at most one code per SCROLL_DIV cycles leaves the FIFO.

## Configuration
- ADN_SEQ_BLINK_N_EN defined: 1-bit blink phase toggles on every tick, and holds while freeze=1. While phase=1, valid digits holding N (111) show 7'b1111111; other digits are unaffected. clear resets phase to 0.
- Not defined: no blink logic; N always shows 1001000.

## Test plan
- Reset, then idle 100 cycles with SCROLL_DIV=4 → hex all 1s, in_ready=1, fifo_count=0, shown_cnt=0.
- SCROLL_DIV=4, NUM_DIGITS=4: push A,G,T,C back-to-back → after 4 ticks hex = {0001000,1000010,1001110,1000110} (digit3..digit0), shown_cnt=4, fifo_count=0.
- FIFO_DEPTH=4, freeze=1: hold in_valid for 6 codes → exactly 4 accepted, in_ready=0 from the cycle after the 4th push, fifo_count=4. Release freeze → first pop after 4 cycles, in_ready=1 the cycle after.
- Push a code in the exact tick cycle with FIFO holding 1 entry → fifo_count stays 1, window gets the older code.
- clear asserted together with in_valid and tick → fifo_count=0, hex all 1s, shown_cnt=0, pushed code discarded.
- With ADN_SEQ_BLINK_N_EN, push N then idle → digit 0 alternates 1001000 / 1111111 on successive ticks; without the macro it stays 1001000. Push code 000 → digit shows 0110110.
